// File: rtl/count_seq_ctrl.sv
// Run controller for the 00-59 BCD counter: paces count enables, issues clears,
// stops on a programmable target and tallies 59->00 wraps.
module count_seq_ctrl #(
    parameter int TICK_DIV = 50_000_000,
    parameter int WRAP_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_start,
    input  logic              btn_stop,
    input  logic              btn_clear,
    input  logic [3:0]        target_tens,
    input  logic [3:0]        target_units,
    input  logic [3:0]        cnt_tens,
    input  logic [3:0]        cnt_units,
    input  logic              cnt_f,
    output logic              cnt_start,
    output logic              cnt_clear,
    output logic              running,
    output logic              alarm,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic [1:0]        state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    state_t        state;
    logic [PW-1:0] prescaler;
    logic          target_valid;
    logic          match;
    logic          at_59;
    logic          unused;

    // Out-of-range targets can never equal a legal count, so they never stop the run.
    assign target_valid = (target_tens <= 4'd5) && (target_units <= 4'd9);
    assign match        = target_valid && (cnt_tens == target_tens) && (cnt_units == target_units);
    assign at_59        = (cnt_tens == 4'd5) && (cnt_units == 4'd9);
    assign unused       = cnt_f;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            prescaler <= '0;
            wrap_cnt  <= '0;
            cnt_start <= 1'b0;
            cnt_clear <= 1'b0;
        end else begin
            cnt_start <= 1'b0;
            cnt_clear <= 1'b0;
            if (btn_clear) begin
                state     <= IDLE;
                prescaler <= '0;
                wrap_cnt  <= '0;
                cnt_clear <= 1'b1;
            end else begin
                case (state)
                    IDLE, PAUSE: begin
                        if (btn_start && !btn_stop) begin
                            state <= RUN;
                        end
                    end
                    RUN: begin
                        if (btn_stop) begin
                            state <= PAUSE;
                        end else if (match) begin
                            state <= DONE;
                        end else if (prescaler == LAST) begin
                            // The wrap is credited with the pulse that carries 59 over to 00.
                            prescaler <= '0;
                            cnt_start <= 1'b1;
                            if (at_59) begin
                                wrap_cnt <= wrap_cnt + 1'b1;
                            end
                        end else begin
                            prescaler <= prescaler + 1'b1;
                        end
                    end
                    DONE: begin
                        state <= DONE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign running = (state == RUN);
    assign alarm   = (state == DONE);
    assign state_o = state;

endmodule
